// File: rtl/multicycle_controller_if.sv
// Control bus between the instruction decoder, the multicycle controller and
// the datapath/memory side.
//
// Handshake: start is a single-cycle request qualified by waiting. The
// controller only accepts start on an edge where waiting=1 (state WAIT); start
// seen in any other state is dropped. opcode/ALU_op must stay stable from the
// accepting edge until waiting returns to 1.
interface multicycle_controller_if;
  logic       start;
  logic [2:0] opcode;
  logic [1:0] ALU_op;
  logic       waiting;
  logic       halted;
  logic       illegal;
  logic [1:0] reg_sel;
  logic [1:0] wb_sel;
  logic       w_en;
  logic       en_A;
  logic       en_B;
  logic       en_C;
  logic       en_status;
  logic       sel_A;
  logic       sel_B;
  logic       load_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [4:0] state_dbg;

  // Controller side.
  modport master (
    input  start, opcode, ALU_op,
    output waiting, halted, illegal, reg_sel, wb_sel, w_en,
           en_A, en_B, en_C, en_status, sel_A, sel_B,
           load_addr, mem_rd, mem_wr, state_dbg
  );

  // Decoder / datapath side.
  modport slave (
    output start, opcode, ALU_op,
    input  waiting, halted, illegal, reg_sel, wb_sel, w_en,
           en_A, en_B, en_C, en_status, sel_A, sel_B,
           load_addr, mem_rd, mem_wr, state_dbg
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle datapath controller: one Moore state per cycle, LDR/STR memory
// sequencing with MEM_WAIT extra strobe cycles, HALT and illegal-opcode
// handling. Current state is visible on bus.state_dbg.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN -- when defined, an undefined
// opcode parks in a sticky trap state (illegal held) until rst.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [2:0]  HALT_OP  = 3'b111
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [4:0] {
    S_WAIT, S_WB_IMM, S_GET_A, S_GET_B, S_EXEC, S_EXEC_MV, S_EXEC_S, S_WB,
    S_ADDR, S_LDADDR, S_RD, S_WB_MEM, S_GET_RD, S_PASS, S_WR, S_HALT,
    S_ILLEGAL
  } state_t;

  localparam logic [3:0] MW = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // State and wait-counter registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_WAIT;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state decode, memory wait counting and Moore output decode.
  always_ff @(posedge clk) begin end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bus.waiting   = 1'b0;
    bus.halted    = 1'b0;
    bus.illegal   = 1'b0;
    bus.reg_sel   = 2'b00;
    bus.wb_sel    = 2'b00;
    bus.w_en      = 1'b0;
    bus.en_A      = 1'b0;
    bus.en_B      = 1'b0;
    bus.en_C      = 1'b0;
    bus.en_status = 1'b0;
    bus.sel_A     = 1'b0;
    bus.sel_B     = 1'b0;
    bus.load_addr = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.state_dbg = state_q;

    case (state_q)
      S_WAIT: begin
        bus.waiting = 1'b1;
        bus.reg_sel = 2'b01;
        bus.wb_sel  = 2'b10;
        if (bus.start) begin
          // No separate decode cycle: jump straight to the first step.
          if (bus.opcode == HALT_OP)                            state_d = S_HALT;
          else if (bus.opcode == 3'b110 && bus.ALU_op == 2'b10) state_d = S_WB_IMM;
          else if (bus.opcode == 3'b110 && bus.ALU_op == 2'b00) state_d = S_GET_B;
          else if (bus.opcode == 3'b101 && bus.ALU_op == 2'b11) state_d = S_GET_B;
          else if (bus.opcode == 3'b101)                        state_d = S_GET_A;
          else if (bus.opcode == 3'b011 && bus.ALU_op == 2'b00) state_d = S_GET_A;
          else if (bus.opcode == 3'b100 && bus.ALU_op == 2'b00) state_d = S_GET_A;
          else                                                  state_d = S_ILLEGAL;
        end
      end
      S_WB_IMM: begin
        bus.reg_sel = 2'b10;
        bus.wb_sel  = 2'b10;
        bus.w_en    = 1'b1;
        state_d     = S_WAIT;
      end
      S_GET_A: begin
        bus.reg_sel = 2'b10;
        bus.en_A    = 1'b1;
        // Memory instructions compute the address; ALU ops fetch B.
        if (bus.opcode == 3'b011 || bus.opcode == 3'b100) state_d = S_ADDR;
        else                                               state_d = S_GET_B;
      end
      S_GET_B: begin
        bus.reg_sel = 2'b00;
        bus.en_B    = 1'b1;
        if (bus.opcode == 3'b110 || bus.ALU_op == 2'b11) state_d = S_EXEC_MV;
        else if (bus.ALU_op == 2'b01)                    state_d = S_EXEC_S;
        else                                             state_d = S_EXEC;
      end
      S_EXEC: begin
        bus.en_C = 1'b1;
        state_d  = S_WB;
      end
      S_EXEC_MV: begin
        bus.sel_A = 1'b1;
        bus.en_C  = 1'b1;
        state_d   = S_WB;
      end
      S_EXEC_S: begin
        bus.en_status = 1'b1;
        state_d       = S_WAIT;
      end
      S_WB: begin
        bus.reg_sel = 2'b01;
        bus.wb_sel  = 2'b00;
        bus.w_en    = 1'b1;
        state_d     = S_WAIT;
      end
      S_ADDR: begin
        bus.sel_B = 1'b1;
        bus.en_C  = 1'b1;
        state_d   = S_LDADDR;
      end
      S_LDADDR: begin
        bus.load_addr = 1'b1;
        if (bus.opcode == 3'b011) begin
          state_d = S_RD;
          cnt_d   = MW;
        end else begin
          state_d = S_GET_RD;
        end
      end
      S_RD: begin
        bus.mem_rd = 1'b1;
        if (cnt_q == 4'd0) state_d = S_WB_MEM;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WB_MEM: begin
        bus.reg_sel = 2'b01;
        bus.wb_sel  = 2'b11;
        bus.w_en    = 1'b1;
        state_d     = S_WAIT;
      end
      S_GET_RD: begin
        bus.reg_sel = 2'b01;
        bus.en_B    = 1'b1;
        state_d     = S_PASS;
      end
      S_PASS: begin
        bus.sel_A = 1'b1;
        bus.en_C  = 1'b1;
        state_d   = S_WR;
        cnt_d     = MW;
      end
      S_WR: begin
        bus.mem_wr = 1'b1;
        if (cnt_q == 4'd0) state_d = S_WAIT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_HALT: begin
        bus.halted  = 1'b1;
        bus.reg_sel = 2'b01;
        bus.wb_sel  = 2'b10;
      end
      S_ILLEGAL: begin
        bus.illegal = 1'b1;
        bus.reg_sel = 2'b01;
        bus.wb_sel  = 2'b10;
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_d = S_ILLEGAL;
`else
        state_d = S_WAIT;
`endif
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: three instances with MEM_WAIT of
// 0, 2 and 3 share stimulus; each sequence checks the chosen instance's full
// output vector cycle by cycle against hand-written expected vectors.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic [1:0] alu_op = 2'b00;

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] exp_q[$];

  // Vector layout: waiting, halted, illegal, reg_sel[1:0], wb_sel[1:0],
  // w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, load_addr, mem_rd, mem_wr
  localparam logic [16:0] V_IDLE  = {3'b100, 2'b01, 2'b10, 10'b0000000000};
  localparam logic [16:0] V_GET_A = {3'b000, 2'b10, 2'b00, 10'b0100000000};
  localparam logic [16:0] V_GET_B = {3'b000, 2'b00, 2'b00, 10'b0010000000};
  localparam logic [16:0] V_EXEC  = {3'b000, 2'b00, 2'b00, 10'b0001000000};
  localparam logic [16:0] V_EXMV  = {3'b000, 2'b00, 2'b00, 10'b0001010000};
  localparam logic [16:0] V_EXS   = {3'b000, 2'b00, 2'b00, 10'b0000100000};
  localparam logic [16:0] V_WB    = {3'b000, 2'b01, 2'b00, 10'b1000000000};
  localparam logic [16:0] V_WBIMM = {3'b000, 2'b10, 2'b10, 10'b1000000000};
  localparam logic [16:0] V_ADDR  = {3'b000, 2'b00, 2'b00, 10'b0001001000};
  localparam logic [16:0] V_LDA   = {3'b000, 2'b00, 2'b00, 10'b0000000100};
  localparam logic [16:0] V_RD    = {3'b000, 2'b00, 2'b00, 10'b0000000010};
  localparam logic [16:0] V_WBMEM = {3'b000, 2'b01, 2'b11, 10'b1000000000};
  localparam logic [16:0] V_GETRD = {3'b000, 2'b01, 2'b00, 10'b0010000000};
  localparam logic [16:0] V_WR    = {3'b000, 2'b00, 2'b00, 10'b0000000001};
  localparam logic [16:0] V_HALT  = {3'b010, 2'b01, 2'b10, 10'b0000000000};
  localparam logic [16:0] V_ILL   = {3'b001, 2'b01, 2'b10, 10'b0000000000};

  multicycle_controller_if if0 ();
  multicycle_controller_if if2 ();
  multicycle_controller_if if3 ();

  assign if0.start = start;
  assign if0.opcode = opcode;
  assign if0.ALU_op = alu_op;
  assign if2.start = start;
  assign if2.opcode = opcode;
  assign if2.ALU_op = alu_op;
  assign if3.start = start;
  assign if3.opcode = opcode;
  assign if3.ALU_op = alu_op;

  multicycle_controller #(.MEM_WAIT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  multicycle_controller #(.MEM_WAIT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  multicycle_controller #(.MEM_WAIT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  logic [16:0] vec0, vec2, vec3;
  assign vec0 = {if0.waiting, if0.halted, if0.illegal, if0.reg_sel, if0.wb_sel,
                 if0.w_en, if0.en_A, if0.en_B, if0.en_C, if0.en_status,
                 if0.sel_A, if0.sel_B, if0.load_addr, if0.mem_rd, if0.mem_wr};
  assign vec2 = {if2.waiting, if2.halted, if2.illegal, if2.reg_sel, if2.wb_sel,
                 if2.w_en, if2.en_A, if2.en_B, if2.en_C, if2.en_status,
                 if2.sel_A, if2.sel_B, if2.load_addr, if2.mem_rd, if2.mem_wr};
  assign vec3 = {if3.waiting, if3.halted, if3.illegal, if3.reg_sel, if3.wb_sel,
                 if3.w_en, if3.en_A, if3.en_B, if3.en_C, if3.en_status,
                 if3.sel_A, if3.sel_B, if3.load_addr, if3.mem_rd, if3.mem_wr};

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [16:0] pick(input int which);
    if (which == 2)      return vec2;
    else if (which == 3) return vec3;
    else                 return vec0;
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    start = 1'b0;
    step();
    check({tag, "_rst0"}, vec0, V_IDLE);
    check({tag, "_rst2"}, vec2, V_IDLE);
    check({tag, "_rst3"}, vec3, V_IDLE);
    rst = 1'b0;
  endtask

  // Pulse start with op/alu, then check one expected vector per edge.
  task automatic run_seq(input string tag, input int which,
                         input logic [2:0] op, input logic [1:0] alu);
    int k;
    k = 0;
    opcode = op;
    alu_op = alu;
    start = 1'b1;
    while (exp_q.size() > 0) begin
      step();
      start = 1'b0;
      check($sformatf("%s_c%0d", tag, k), pick(which), exp_q.pop_front());
      k++;
    end
  endtask

  initial begin
    #2;
    // Reset then idle with start low.
    do_reset("reset");
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("idle_%0d", i), vec0, V_IDLE);
    end

    // ADD: 5 edges to waiting.
    exp_q = '{V_GET_A, V_GET_B, V_EXEC, V_WB, V_IDLE};
    run_seq("add", 0, 3'b101, 2'b00);

    // AND takes the same route.
    exp_q = '{V_GET_A, V_GET_B, V_EXEC, V_WB, V_IDLE};
    run_seq("and", 0, 3'b101, 2'b10);

    // MOV imm: 2 edges.
    exp_q = '{V_WBIMM, V_IDLE};
    run_seq("movi", 0, 3'b110, 2'b10);

    // MOV reg and MVN: 4 edges, A forced to zero.
    exp_q = '{V_GET_B, V_EXMV, V_WB, V_IDLE};
    run_seq("movr", 0, 3'b110, 2'b00);
    exp_q = '{V_GET_B, V_EXMV, V_WB, V_IDLE};
    run_seq("mvn", 0, 3'b101, 2'b11);

    // CMP: status only, no write-back.
    exp_q = '{V_GET_A, V_GET_B, V_EXS, V_IDLE};
    run_seq("cmp", 0, 3'b101, 2'b01);

    // LDR with MEM_WAIT=2: mem_rd for 3 cycles, waiting on 8th edge.
    do_reset("pre_ldr");
    exp_q = '{V_GET_A, V_ADDR, V_LDA, V_RD, V_RD, V_RD, V_WBMEM, V_IDLE};
    run_seq("ldr2", 2, 3'b011, 2'b00);

    // STR with MEM_WAIT=0: waiting on 7th edge, no w_en.
    do_reset("pre_str");
    exp_q = '{V_GET_A, V_ADDR, V_LDA, V_GETRD, V_EXMV, V_WR, V_IDLE};
    run_seq("str0", 0, 3'b100, 2'b00);

    // LDR with MEM_WAIT=3, reset during the second RD cycle.
    do_reset("pre_ldr3");
    exp_q = '{V_GET_A, V_ADDR, V_LDA, V_RD, V_RD};
    run_seq("ldr3", 3, 3'b011, 2'b00);
    do_reset("ldr3_abort");
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ldr3_after_%0d", i), vec3, V_IDLE);
    end
    exp_q = '{V_WBIMM, V_IDLE};
    run_seq("ldr3_movi", 3, 3'b110, 2'b10);

    // Illegal opcodes.
    do_reset("pre_ill");
`ifdef CTRL_ILLEGAL_TRAP_EN
    exp_q = '{V_ILL, V_ILL, V_ILL};
    run_seq("ill000", 0, 3'b000, 2'b00);
    start = 1'b1;
    opcode = 3'b110;
    alu_op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("trap_hold_%0d", i), vec0, V_ILL);
    end
    do_reset("trap_exit");
`else
    exp_q = '{V_ILL, V_IDLE};
    run_seq("ill000", 0, 3'b000, 2'b00);
    exp_q = '{V_ILL, V_IDLE};
    run_seq("ill011_01", 0, 3'b011, 2'b01);
    exp_q = '{V_ILL, V_IDLE};
    run_seq("ill100_10", 0, 3'b100, 2'b10);
`endif

    // HALT: sticky with start held high, cleared only by rst.
    exp_q = '{V_HALT};
    run_seq("halt", 0, 3'b111, 2'b00);
    start = 1'b1;
    opcode = 3'b101;
    alu_op = 2'b00;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("halt_hold_%0d", i), vec0, V_HALT);
    end
    do_reset("halt_exit");
    step();
    check("halt_exit_idle", vec0, V_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Next-generation FSM controller for the multicycle datapath (register file, A/B/C regs, shifter, ALU, status).
- Adds LDR/STR memory sequencing with parametrised memory wait states, a HALT instruction and illegal-opcode detection.
- Sits between the instruction register decoder and the datapath/memory interface.
- Drives every datapath enable/select and the memory read/write strobes, one state per cycle.

Parameters:
- MEM_WAIT, 0: extra cycles each memory strobe is held; range 0..15; strobe width = MEM_WAIT+1 cycles.
- HALT_OP, 3'b111: opcode decoded as HALT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin execution of the decoded instruction; sampled only in WAIT.
- opcode  in  3  instruction opcode.
- ALU_op  in  2  ALU operation / sub-opcode.
- waiting  out  1  high only in WAIT.
- halted  out  1  high only in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- reg_sel  out  2  register file address select: 10=Rn, 01=Rd, 00=Rm.
- wb_sel  out  2  write-back source: 00=C, 10=sximm8, 11=mem_data, 01 reserved (never driven).
- w_en  out  1  register file write.
- en_A, en_B, en_C, en_status  out  1 each  datapath register loads.
- sel_A  out  1  1 selects zero on the ALU A input.
- sel_B  out  1  1 selects sximm5 on the ALU B input.
- load_addr  out  1  load C[8:0] into the data address register.
- mem_rd, mem_wr  out  1 each  memory strobes.

Behaviour:
- All outputs are Moore, decoded from state only.
- Idle vector (WAIT, reset): reg_sel=01, wb_sel=10, all other outputs 0; waiting=1.
- rst has priority over all inputs. On any edge with rst=1 the next state is WAIT and the wait counter clears, including mid-instruction, mid-memory-strobe and from HALT/TRAP.
- In WAIT with start=1, the next state is the first state of the instruction; there is no separate decode cycle. start is ignored in all other states.
- The last state of every instruction returns to WAIT, except HALT.
- Sequences (state: asserted outputs):
  - MOV imm (110/10): WB_IMM: reg_sel=10, wb_sel=10, w_en.
  - MOV reg (110/00) and MVN (101/11): GET_B: reg_sel=00, en_B; EXEC: sel_A, en_C; WB: reg_sel=01, wb_sel=00, w_en.
  - ADD (101/00) and AND (101/10): GET_A: reg_sel=10, en_A; GET_B; EXEC: en_C; WB.
  - CMP (101/01): GET_A; GET_B; EXEC_S: en_status.
  - LDR (011/00): GET_A; ADDR: sel_B, en_C; LDADDR: load_addr; RD: mem_rd; WB_MEM: reg_sel=01, wb_sel=11, w_en.
  - STR (100/00): GET_A; ADDR; LDADDR; GET_RD: reg_sel=01, en_B; PASS: sel_A, en_C; WR: mem_wr.
  - HALT (opcode==HALT_OP): HALT; halted=1, idle vector otherwise; exits only on rst.
- RD and WR hold for exactly MEM_WAIT+1 cycles using a 4-bit down-counter. The counter is loaded with MEM_WAIT on entry and the state advances when the counter is 0. With MEM_WAIT=0 each is a single cycle.
- Undefined opcode/ALU_op combination (e.g. 000, 011/01, 100/10): one ILLEGAL state with illegal=1, then WAIT. No register or memory write occurs.
- Cycle counts from the start edge to waiting=1: MOV imm 2; MOV/MVN 4; ADD/AND 5; CMP 4; LDR 6+MEM_WAIT; STR 7+MEM_WAIT.
- opcode and ALU_op are sampled at each edge. The instruction register must hold them stable until waiting=1.

Optional Feature:
- CTRL_ILLEGAL_TRAP_EN defined: an undefined opcode enters a sticky TRAP state with illegal held at 1 and the idle vector otherwise. TRAP is exited only by rst.
- CTRL_ILLEGAL_TRAP_EN undefined: a one-cycle ILLEGAL pulse, then WAIT, as described under Behaviour.

Test Plan:
- rst=1 for one edge, then rst=0, start=0 for 3 edges -> idle vector each cycle, waiting=1, halted=0.
- ADD (101/00) with start pulse -> GET_A, GET_B, EXEC, WB vectors in order {reg_sel=10,en_A}, {reg_sel=00,en_B}, {en_C}, {reg_sel=01,wb_sel=00,w_en}; waiting=1 on the 5th edge.
- LDR with MEM_WAIT=2 -> mem_rd high for exactly 3 consecutive cycles; WB_MEM asserts wb_sel=11 and w_en; waiting=1 on the 8th edge.
- STR with MEM_WAIT=0 -> load_addr is a 1-cycle pulse before GET_RD; mem_wr is 1 cycle; w_en is never asserted; waiting=1 on the 7th edge.
- rst=1 asserted during the second RD cycle of LDR (MEM_WAIT=3) -> idle vector after that edge; no w_en afterwards; a subsequent MOV imm completes in 2 cycles.
- opcode=000 -> illegal=1 for 1 cycle then WAIT (macro off), or illegal held and start ignored until rst (macro on). HALT_OP -> halted=1 persists 10 cycles with start=1, and clears on rst.
